add_seq_arbiter: RTL and testbench

- Shares one 16-bit carry-lookahead adder slice between two requesters and sequences multi-word (WORDS×16-bit) add/subtract over WORDS cycles.
- The inter-word carry is held in a register and fed back as carry-in on the next cycle.
- Sits between the DE2 front-end logic and the adder datapath.
- Uses a valid/ready handshake on the request side and the result side, with round-robin arbitration.

---
 rtl/add_seq_pkg.sv | 13 +
 rtl/cla16_cin.sv | 50 +++++
 rtl/add_seq_arbiter.sv | 125 ++++++++++++
 tb/tb_add_seq_arbiter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/add_seq_pkg.sv
// Shared types and helpers for the sequenced multi-word adder arbiter.
package add_seq_pkg;

  localparam int WORD_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  // Bit offset of a 16-bit word within a multi-word operand.
  function automatic int word_slice(input int index);
    return index * WORD_W;
  endfunction

endpackage

// File: rtl/cla16_cin.sv
// 16-bit carry-lookahead adder with external carry-in: four 4-bit lookahead
// groups joined by a second lookahead level. Purely combinational.
module cla16_cin
  import add_seq_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              Cin,
  output logic              Cout,
  output logic [WORD_W-1:0] S
);

  function automatic logic [3:0] carries4(input logic [3:0] p4, input logic [3:0] g4,
                                          input logic cin);
    logic [3:0] c4;
    c4[0] = cin;
    c4[1] = g4[0] | (p4[0] & cin);
    c4[2] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & cin);
    c4[3] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0])
          | (p4[2] & p4[1] & p4[0] & cin);
    return c4;
  endfunction

  function automatic logic gen4(input logic [3:0] p4, input logic [3:0] g4);
    return g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1])
         | (p4[3] & p4[2] & p4[1] & g4[0]);
  endfunction

  logic [WORD_W-1:0] p;
  logic [WORD_W-1:0] g;
  logic [WORD_W-1:0] c;
  logic [3:0]        gp;
  logic [3:0]        gg;
  logic [3:0]        gc;

  assign p = a ^ b;
  assign g = a & b;

  for (genvar k = 0; k < 4; k++) begin : g_grp
    assign gg[k]       = gen4(p[4*k +: 4], g[4*k +: 4]);
    assign gp[k]       = &p[4*k +: 4];
    assign c[4*k +: 4] = carries4(p[4*k +: 4], g[4*k +: 4], gc[k]);
  end

  // Group carries depend only on group P/G and Cin, never on c[].
  assign gc   = carries4(gp, gg, Cin);
  assign Cout = gen4(gp, gg) | (&gp & Cin);
  assign S    = p ^ c;

endmodule

// File: rtl/add_seq_arbiter.sv
// Round-robin shares one 16-bit CLA slice between two requesters, sequencing a
// WORDS-word add/subtract one word per cycle with a registered inter-word carry.
module add_seq_arbiter
  import add_seq_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int NREQ  = 2
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [NREQ-1:0]             req_valid,
  output logic [NREQ-1:0]             req_ready,
  input  logic [NREQ*WORD_W*WORDS-1:0] req_a,
  input  logic [NREQ*WORD_W*WORDS-1:0] req_b,
  input  logic [NREQ-1:0]             req_sub,
  output logic                        res_valid,
  input  logic                        res_ready,
  output logic [WORD_W*WORDS-1:0]     res_sum,
  output logic                        res_cout,
  output logic                        res_ovf,
  output logic                        res_id,
  output logic                        busy
);

  localparam int W     = WORD_W * WORDS;
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;

  state_e           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic             last_grant_q;
  logic [W-1:0]     a_q;
  logic [W-1:0]     b_q;
  logic [W-1:0]     res_sum_q;
  logic             res_cout_q;
  logic             res_ovf_q;
  logic             res_id_q;

  logic              any_vld;
  logic              gnt_id;
  logic [W-1:0]      op_a;
  logic [W-1:0]      op_b;
  logic              op_sub;
  int                base;
  logic [WORD_W-1:0] word_a;
  logic [WORD_W-1:0] word_b;
  logic [WORD_W-1:0] word_s;
  logic              word_cout;
  logic              last_word;

  // The requester that did not win last time has priority.
  assign any_vld = |req_valid;
  assign gnt_id  = req_valid[~last_grant_q] ? ~last_grant_q : last_grant_q;
  assign op_a    = gnt_id ? req_a[W +: W] : req_a[0 +: W];
  assign op_b    = gnt_id ? req_b[W +: W] : req_b[0 +: W];
  assign op_sub  = req_sub[gnt_id];

  // Gated by Reset_n so no handshake can complete while reset is held.
  assign req_ready = (Reset_n && state_q == IDLE && any_vld) ? (NREQ'(1) << gnt_id) : '0;

  assign base      = word_slice(int'(idx_q));
  assign word_a    = a_q[base +: WORD_W];
  assign word_b    = b_q[base +: WORD_W];
  assign last_word = (idx_q == IDX_W'(WORDS - 1));

  cla16_cin u_cla (
    .a    (word_a),
    .b    (word_b),
    .Cin  (carry_q),
    .Cout (word_cout),
    .S    (word_s)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      carry_q      <= 1'b0;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      res_sum_q    <= '0;
      res_cout_q   <= 1'b0;
      res_ovf_q    <= 1'b0;
      res_id_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_vld) begin
            a_q          <= op_a;
            b_q          <= op_sub ? ~op_b : op_b;
            carry_q      <= op_sub;
            idx_q        <= '0;
            last_grant_q <= gnt_id;
            res_id_q     <= gnt_id;
            state_q      <= RUN;
          end
        end
        RUN: begin
          res_sum_q[base +: WORD_W] <= word_s;
          carry_q                   <= word_cout;
          idx_q                     <= idx_q + IDX_W'(1);
          if (last_word) begin
            res_cout_q <= word_cout;
            res_ovf_q  <= (word_a[WORD_W-1] == word_b[WORD_W-1]) &&
                          (word_s[WORD_W-1] != word_a[WORD_W-1]);
            state_q    <= DONE;
          end
        end
        DONE: begin
          if (res_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign res_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign res_sum   = res_sum_q;
  assign res_cout  = res_cout_q;
  assign res_ovf   = res_ovf_q;
  assign res_id    = res_id_q;

endmodule

// File: tb/tb_add_seq_arbiter.sv
// Directed self-checking bench for add_seq_arbiter with WORDS=4.
module tb_add_seq_arbiter;

  localparam int WORDS = 4;
  localparam int W     = 16 * WORDS;

  logic           Clk;
  logic           Reset_n;
  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [2*W-1:0] req_a;
  logic [2*W-1:0] req_b;
  logic [1:0]     req_sub;
  logic           res_valid;
  logic           res_ready;
  logic [W-1:0]   res_sum;
  logic           res_cout;
  logic           res_ovf;
  logic           res_id;
  logic           busy;

  add_seq_arbiter #(.WORDS(WORDS), .NREQ(2)) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_sum   (res_sum),
    .res_cout  (res_cout),
    .res_ovf   (res_ovf),
    .res_id    (res_id),
    .busy      (busy)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic         id;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } vec_t;

  vec_t tbl[8];

  // Drive one request, wait for its grant and result, check everything, accept it.
  task automatic run_op(input logic [1:0] v, input logic [1:0] sub,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1,
                        input logic exp_id, input logic [W-1:0] es,
                        input logic ec, input logic eo, input bit drop);
    int  t0;
    bit  got;
    req_valid = v;
    req_sub   = sub;
    req_a     = {a1, a0};
    req_b     = {b1, b0};
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      if (|req_ready) begin got = 1; break; end
      @(negedge Clk);
    end
    if (!got) begin
      check("grant_timeout", 0, 1);
      req_valid = 2'b00;
      return;
    end
    check("grant", W'(req_ready), W'(2'b01 << exp_id));
    t0 = cyc;
    @(posedge Clk);
    #1;
    if (drop) req_valid = 2'b00;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (res_valid) begin got = 1; break; end
    end
    if (!got) begin
      check("result_timeout", 0, 1);
      return;
    end
    check("latency", W'(cyc - t0), W'(WORDS + 1));
    check("sum", res_sum, es);
    check("cout", W'(res_cout), W'(ec));
    check("ovf", W'(res_ovf), W'(eo));
    check("id", W'(res_id), W'(exp_id));
    res_ready = 1'b1;
    @(posedge Clk);
    #1;
    res_ready = 1'b0;
    @(negedge Clk);
    check("valid_drop", W'(res_valid), 0);
  endtask

  initial begin
    logic [W-1:0] held;
    bit           got;

    tbl[0] = '{1'b0, 1'b0, 64'h0000_0000_0000_FFFF, 64'h1, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 64'h5, 64'h7, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
    tbl[4] = '{1'b0, 1'b1, 64'h7, 64'h5, 64'h2, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
    tbl[6] = '{1'b1, 1'b0, 64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111,
               64'h2345_6789_ABCD_F001, 1'b0, 1'b0};
    tbl[7] = '{1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 1'b1, 1'b1};

    // Reset held with both requesters asking.
    Reset_n   = 1'b0;
    req_valid = 2'b11;
    req_sub   = 2'b00;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b0;
    repeat (3) @(negedge Clk);
    check("rst_req_ready", W'(req_ready), 0);
    check("rst_res_valid", W'(res_valid), 0);
    check("rst_busy", W'(busy), 0);
    check("rst_res_sum", res_sum, 0);
    check("rst_flags", W'({res_cout, res_ovf, res_id}), 0);
    Reset_n = 1'b1;
    #1;
    check("rst_first_grant", W'(req_ready), W'(2'b01));
    req_valid = 2'b00;
    @(negedge Clk);

    // Single-requester vectors; the last three show req1 winning repeatedly alone.
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].id ? 2'b10 : 2'b01, {tbl[i].sub, tbl[i].sub},
             tbl[i].a, tbl[i].b, tbl[i].a, tbl[i].b,
             tbl[i].id, tbl[i].sum, tbl[i].cout, tbl[i].ovf, 1'b1);
    end

    // Both requesters hold valid continuously: grants alternate starting with 0.
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, 2'b00, 64'd1, 64'd2, 64'd10, 64'd20,
             i[0], (i % 2 == 1) ? 64'd30 : 64'd3, 1'b0, 1'b0, 1'b0);
    end
    req_valid = 2'b00;
    @(negedge Clk);

    // Backpressure: result held with res_ready low, other requester kept waiting.
    req_valid = 2'b11;
    req_a     = {64'd100, 64'd5};
    req_b     = {64'd200, 64'd6};
    req_sub   = 2'b00;
    #1;
    check("bp_grant", W'(req_ready), W'(2'b01));
    @(posedge Clk);
    #1;
    got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (res_valid) begin got = 1; break; end
      check("bp_run_ready", W'(req_ready), 0);
    end
    if (!got) check("bp_timeout", 0, 1);
    held = res_sum;
    check("bp_sum", held, 64'd11);
    for (int k = 0; k < 10; k++) begin
      @(negedge Clk);
      check("bp_valid", W'(res_valid), 1);
      check("bp_stable", res_sum, held);
      check("bp_ready", W'(req_ready), 0);
    end
    req_valid = 2'b00;
    res_ready = 1'b1;
    @(posedge Clk);
    #1;
    res_ready = 1'b0;
    @(negedge Clk);

    // Abort: reset pulsed during RUN at word index 2.
    req_valid = 2'b01;
    req_a     = {64'd0, 64'hAAAA_BBBB_CCCC_DDDD};
    req_b     = {64'd0, 64'h1111_1111_1111_1111};
    #1;
    check("ab_grant", W'(req_ready), W'(2'b01));
    @(posedge Clk);
    #1;
    req_valid = 2'b00;
    @(posedge Clk);
    @(posedge Clk);
    #1;
    check("ab_busy_before", W'(busy), 1);
    Reset_n = 1'b0;
    #2;
    check("ab_res_valid", W'(res_valid), 0);
    check("ab_busy", W'(busy), 0);
    check("ab_sum", res_sum, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    repeat (6) begin
      @(negedge Clk);
      check("ab_no_result", W'(res_valid), 0);
    end
    run_op(2'b11, 2'b00, 64'h1234, 64'h1, 64'h9, 64'h9, 1'b0, 64'h1235, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
